// File: rtl/mini_risc_fetch_if.sv
// mini_risc_fetch_if: instruction-memory, redirect and decode-side signals of the fetch unit
interface mini_risc_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;
  logic [ADDR_W-1:0] dbg_pc_low;
  modport master (
    output imem_en, imem_addr, out_valid, out_instr, out_pc, halted, dbg_pc_low,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_en, imem_addr, out_valid, out_instr, out_pc, halted, dbg_pc_low,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/mini_risc_fetch.sv
// mini_risc_fetch: credit-based instruction fetch with prefetch FIFO, redirect flush and HALT stop
module mini_risc_fetch #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 12,
  parameter int                DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input logic               clk,
  input logic               rst,
  mini_risc_fetch_if.master io_bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_pc, r_req_pc;
  logic              r_inflight, r_halted;
  logic              w_valid, w_pop, w_push, w_en;
  logic [CW-1:0]     w_occ;
  // A request is only issued if its response is guaranteed a free FIFO slot.
  always_comb begin
    w_valid = r_count != '0;
    w_pop   = w_valid & io_bus.out_ready;
    w_occ   = r_count + CW'(r_inflight) - CW'(w_pop);
    w_en    = !rst & !r_halted & !io_bus.redirect_valid & (w_occ < CW'(DEPTH));
    w_push  = r_inflight & !r_halted & !io_bus.redirect_valid;
  end
  assign io_bus.imem_en    = w_en;
  assign io_bus.imem_addr  = r_pc;
  assign io_bus.out_valid  = w_valid;
  assign io_bus.out_instr  = w_valid ? r_mem_data[r_rp] : '0;
  assign io_bus.out_pc     = w_valid ? r_mem_pc[r_rp] : '0;
  assign io_bus.halted     = r_halted;
  assign io_bus.dbg_pc_low = r_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      r_inflight <= w_en;
      if (w_en) r_req_pc <= r_pc;
      if (io_bus.redirect_valid) begin
        r_pc     <= io_bus.redirect_pc;
        r_count  <= '0;
        r_wp     <= '0;
        r_rp     <= '0;
        r_halted <= 1'b0;
      end else begin
        if (w_en) r_pc <= r_pc + ADDR_W'(1);
        if (w_push) r_wp <= r_wp + PW'(1);
        if (w_pop) r_rp <= r_rp + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push && io_bus.imem_rdata == HALT_WORD) r_halted <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wp] <= io_bus.imem_rdata;
      r_mem_pc[r_wp]   <= r_req_pc;
    end
  end
endmodule

// File: tb/tb_mini_risc_fetch.sv
// tb_mini_risc_fetch: vector table, hand-written corner sequences and a random run against a stream-level model
`timescale 1ns/100ps
module tb_mini_risc_fetch;
  localparam int          AW   = 12;
  localparam int          DW   = 32;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  typedef struct {
    logic        rst, rdy, rv;
    logic [11:0] rpc;
    logic        en, v;
    logic [11:0] pc;
    logic [31:0] instr;
    logic [11:0] dbg;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rst_w = 1'b1;
  logic [31:0] mem [4096];
  int total = 0, bad = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  mini_risc_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mini_risc_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) wbus ();
  mini_risc_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2), .RESET_PC(12'd0), .HALT_WORD(HALT))
    dut (.clk(clk), .rst(rst), .io_bus(bus));
  mini_risc_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2), .RESET_PC(12'd4094), .HALT_WORD(HALT))
    dut_w (.clk(clk), .rst(rst_w), .io_bus(wbus));
  always @(posedge clk) bus.imem_rdata <= bus.imem_en ? mem[bus.imem_addr] : $urandom;
  always @(posedge clk) wbus.imem_rdata <= wbus.imem_en ? mem[wbus.imem_addr] : $urandom;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic r, rdy, rv, input logic [11:0] rpc, input logic en, v,
                              input logic [11:0] pc, input logic [31:0] ins, input logic [11:0] dbg);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.en = en; t.v = v;
    t.pc = pc; t.instr = ins; t.dbg = dbg;
    return t;
  endfunction
  initial begin
    logic [11:0] got_pc[$];
    logic [31:0] got_in[$];
    logic [11:0] exp_pc;
    int en_viol, gap, max_gap, accepts;
    bit seen;
    for (int k = 0; k < 4096; k++) mem[k] = 32'(k + 100);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    wbus.out_ready = 1'b1;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc = '0;
    // straight-line stream
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(0, 1, 0, 0, 1, k >= 2, 12'(k - 2), 32'(98 + k), 12'(k)));
    // backpressure
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 100, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 100, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 101, 3));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 2, 102, 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 3, 103, 5));
    // redirect while out_pc=3 is presented
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 1, 0, 0, 1, 1, 12'(k), 32'(100 + k), 12'(k + 2)));
    vecs.push_back(mk(0, 1, 1, 40, 0, 1, 3, 103, 5));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 40));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 41));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 40, 140, 42));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 41, 141, 43));
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.out_ready = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d_en", i), bus.imem_en, vecs[i].en);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].v);
      chk($sformatf("vec%0d_dbg", i), bus.dbg_pc_low, vecs[i].dbg);
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].pc);
        chk($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].instr);
      end
    end
    // HALT at address 5
    mem[5] = HALT;
    @(negedge clk); rst = 1'b1; bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    en_viol = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        got_pc.push_back(bus.out_pc);
        got_in.push_back(bus.out_instr);
      end
      if (bus.halted && bus.imem_en) en_viol++;
      @(negedge clk);
    end
    #1;
    chk("halt_count", got_pc.size(), 6);
    foreach (got_pc[i]) begin
      chk($sformatf("halt_pc%0d", i), got_pc[i], 12'(i));
      chk($sformatf("halt_in%0d", i), got_in[i], mem[i]);
    end
    chk("halt_flag", bus.halted, 1);
    chk("halt_valid_off", bus.out_valid, 0);
    chk("halt_en_off", bus.imem_en, 0);
    chk("halt_en_viol", en_viol, 0);
    mem[5] = 32'd105;
    // async reset pulse while two entries (word0 + HALT) are buffered
    mem[1] = HALT;
    @(negedge clk); rst = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_pre_valid", bus.out_valid, 1);
    chk("mid_pre_halted", bus.halted, 1);
    chk("mid_pre_pc", bus.out_pc, 0);
    #1 rst = 1'b1;
    #0.5;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_halted", bus.halted, 0);
    chk("mid_rst_en", bus.imem_en, 0);
    #0.5 rst = 1'b0;
    mem[1] = 32'd101;
    bus.out_ready = 1'b1;
    #0.5;
    chk("mid_rel_dbg", bus.dbg_pc_low, 0);
    got_pc.delete();
    got_in.delete();
    for (int c = 0; c < 12 && got_pc.size() < 4; c++) begin
      @(negedge clk); #1;
      if (bus.out_valid && bus.out_ready) begin
        got_pc.push_back(bus.out_pc);
        got_in.push_back(bus.out_instr);
      end
    end
    chk("mid_count", got_pc.size(), 4);
    foreach (got_pc[i]) begin
      chk($sformatf("mid_pc%0d", i), got_pc[i], 12'(i));
      chk($sformatf("mid_in%0d", i), got_in[i], mem[i]);
    end
    // PC wrap from RESET_PC=4094
    @(negedge clk); rst_w = 1'b0;
    got_pc.delete();
    got_in.delete();
    for (int c = 0; c < 12 && got_pc.size() < 4; c++) begin
      #1;
      if (wbus.out_valid && wbus.out_ready) begin
        got_pc.push_back(wbus.out_pc);
        got_in.push_back(wbus.out_instr);
      end
      @(negedge clk);
    end
    chk("wrap_count", got_pc.size(), 4);
    foreach (got_pc[i]) begin
      exp_pc = 12'(4094 + i);
      chk($sformatf("wrap_pc%0d", i), got_pc[i], exp_pc);
      chk($sformatf("wrap_in%0d", i), got_in[i], mem[exp_pc]);
    end
    // random traffic against the program-order stream model
    for (int k = 0; k < 4096; k++) if (k % 97 == 50) mem[k] = HALT;
    @(negedge clk); rst = 1'b1; bus.redirect_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_pc = 12'd0; seen = 1'b0; gap = 0; max_gap = 0; accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.out_ready = ($urandom % 4) != 0;
      bus.redirect_valid = ($urandom % 20) == 0;
      bus.redirect_pc = 12'($urandom_range(0, 4095));
      #1;
      if (bus.redirect_valid) chk("rnd_en_redirect", bus.imem_en, 0);
      if (seen && !bus.redirect_valid) begin
        chk("rnd_after_halt_valid", bus.out_valid, 0);
        chk("rnd_after_halt_flag", bus.halted, 1);
        chk("rnd_after_halt_en", bus.imem_en, 0);
      end
      if (bus.out_valid || seen) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc;
        seen = 1'b0;
        gap = 0;
      end else if (bus.out_valid && bus.out_ready) begin
        chk("rnd_pc", bus.out_pc, exp_pc);
        chk("rnd_instr", bus.out_instr, mem[exp_pc]);
        accepts++;
        if (mem[exp_pc] == HALT) seen = 1'b1;
        exp_pc = exp_pc + 12'd1;
      end
    end
    chk("rnd_max_gap_ok", max_gap <= 3, 1);
    chk("rnd_progress", accepts > 300, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
